serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial W-bit subtractor: computes diff = a - b, one bit per clock, LSB first.
- Datapath is a 1-bit full subtractor (difference = a^b^borrow) plus a registered borrow flip-flop.
- Operands are accepted on a valid/ready input handshake; the result is returned on a valid/ready output handshake.
- Pairs with the combinational adder cells as the area-cheap subtraction path for arithmetic units.

Parameters:
W  8  operand/result width in bits; legal range W >= 1

Ports:
clk         input   1  rising-edge clock
rst         input   1  asynchronous, active-high reset
in_valid    input   1  operands a, b valid this cycle
in_ready    output  1  block can accept operands (high only in IDLE)
a           input   W  minuend, sampled on input handshake
b           input   W  subtrahend, sampled on input handshake
out_valid   output  1  diff and borrow_out valid (high only in DONE)
out_ready   input   1  consumer accepts result
diff        output  W  a - b modulo 2^W
borrow_out  output  1  final borrow; 1 iff a < b (unsigned)

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; diff=0, borrow_out=0, out_valid=0.
  - Internal shift registers, borrow flip-flop and bit counter are cleared.
  - in_ready=1 from the first clock after reset deasserts.
- States: IDLE, RUN, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE), driven from the registered state only.
- IDLE:
  - On in_valid & in_ready: capture a into sa and b into sb; clear borrow br=0 and count=0; go to RUN.
  - Otherwise stay in IDLE. out_ready is ignored.
- RUN, one bit per cycle:
  - d = sa[0]^sb[0]^br.
  - br <= (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br).
  - sa, sb shift right by 1.
  - Result register shifts right with d entering at bit W-1.
  - count increments.
  - When count == W-1 on this edge, go to DONE; borrow_out <= br_next.
  - in_valid is ignored; operands are never re-sampled.
- Latency: out_valid rises exactly W clock edges after the acceptance edge. W=1 gives 1 cycle.
- DONE:
  - diff and borrow_out are held stable while out_valid=1 and out_ready=0, for any number of cycles.
  - On out_valid & out_ready: go to IDLE. diff and borrow_out keep their values until the next DONE.
- Throughput: at most one operation per W+2 cycles (accept, W shift cycles, handshake). There is no overlap between output and input handshakes.
- Arithmetic:
  - Result is unsigned modulo 2^W.
  - Equals a + ~b + 1 truncated to W bits.
  - borrow_out = ~carry of that sum.
  - Signed callers interpret diff as two's complement; overflow detection is out of scope.
- Counter width: $clog2(W+1), with a minimum of 1.
- Reset mid-operation (RUN or DONE):
  - The operation is aborted and all state returns to reset values immediately.
  - No partial result is ever flagged valid.
- X-safety: a and b may be X when in_valid=0; they must not propagate into state.

Test Plan:
1. W=8: a=100, b=37, handshake at t0 → out_valid high exactly 8 edges later; diff=63 (0x3F), borrow_out=0; in_ready=0 throughout RUN/DONE.
2. W=8: a=5, b=9 → diff=0xFC, borrow_out=1. Also a=0xFF, b=0x01 → diff=0xFE, borrow_out=0. Also a=0, b=0 → diff=0, borrow_out=0.
3. Backpressure: a=0x80, b=0x01, out_ready=0 for 5 cycles after out_valid → diff=0x7F, borrow_out=1… correction: borrow_out=0; values stable all 5 cycles; IDLE follows the cycle after out_ready=1.
4. Reset mid-run: assert rst at RUN count 4 → out_valid=0, diff=0, borrow_out=0 immediately; after release in_ready=1 and the next op (a=3, b=3) yields diff=0, borrow_out=0.
5. Back-to-back: in_valid held high with new a/b every cycle → only IDLE-cycle operands are taken; in_valid during RUN is ignored; results 20-7=13 then 7-20=0xF3, borrow_out=1, in order.
6. W=1 build: all four (a,b) pairs → out_valid 1 edge after accept; (0,1) gives diff=1, borrow_out=1; (1,0) gives diff=1, borrow_out=0; (1,1) and (0,0) give diff=0, borrow_out=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial W-bit subtractor (diff = a - b, LSB first) with valid/ready handshakes
module serial_subtractor #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         borrow_out
);

    localparam int CW = ($clog2(W + 1) < 1) ? 1 : $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [W-1:0]  sa, sb, res, res_next;
    logic          br, br_next, d;
    logic [CW-1:0] count;
    logic          last;

    assign d       = sa[0] ^ sb[0] ^ br;
    assign br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    assign last    = (count == CW'(W - 1));

    // The result fills from the top so that after W shifts bit 0 holds the LSB.
    generate
        if (W == 1) begin : g_res_w1
            assign res_next = d;
        end else begin : g_res_wn
            assign res_next = {d, res[W-1:1]};
        end
    endgenerate

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa         <= '0;
            sb         <= '0;
            res        <= '0;
            br         <= 1'b0;
            count      <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa    <= a;
                        sb    <= b;
                        res   <= '0;
                        br    <= 1'b0;
                        count <= '0;
                    end
                end
                RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    res   <= res_next;
                    br    <= br_next;
                    count <= count + 1'b1;
                    // Outputs update only on completion so they stay stable outside DONE.
                    if (last) begin
                        diff       <= res_next;
                        borrow_out <= br_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (W=8 and W=1 builds)
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iv8 = 1'b0, or8 = 1'b0, rdy8, ov8, bo8;
    logic [7:0] a8 = '0, b8 = '0, d8;
    logic       iv1 = 1'b0, or1 = 1'b0, rdy1, ov1, bo1;
    logic [0:0] a1 = '0, b1 = '0, d1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(or8), .diff(d8), .borrow_out(bo8)
    );

    serial_subtractor #(.W(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1), .a(a1), .b(b1),
        .out_valid(ov1), .out_ready(or1), .diff(d1), .borrow_out(bo1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input int hold);
        logic [7:0] ed;
        logic       eb;
        int         edges;
        ed = x - y;
        eb = (x < y);
        @(negedge clk);
        check("w8_idle_in_ready", rdy8, 1);
        a8 = x; b8 = y; iv8 = 1'b1;
        @(posedge clk);
        #1;
        iv8 = 1'b0; a8 = 'x; b8 = 'x;
        edges = 0;
        while (edges < 64) begin
            @(posedge clk);
            edges++;
            #1;
            if (ov8) break;
            check("w8_run_in_ready", rdy8, 0);
        end
        check("w8_latency", edges, 8);
        check("w8_diff", d8, ed);
        check("w8_borrow", bo8, eb);
        check("w8_done_in_ready", rdy8, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("w8_hold_valid", ov8, 1);
            check("w8_hold_diff", d8, ed);
            check("w8_hold_borrow", bo8, eb);
        end
        @(negedge clk);
        or8 = 1'b1;
        @(posedge clk);
        #1;
        or8 = 1'b0;
        check("w8_post_in_ready", rdy8, 1);
        check("w8_post_valid", ov8, 0);
        check("w8_post_diff_kept", d8, ed);
    endtask

    task automatic op1(input logic x, input logic y);
        int edges;
        @(negedge clk);
        check("w1_idle_in_ready", rdy1, 1);
        a1 = x; b1 = y; iv1 = 1'b1;
        @(posedge clk);
        #1;
        iv1 = 1'b0;
        edges = 0;
        while (edges < 16) begin
            @(posedge clk);
            edges++;
            #1;
            if (ov1) break;
        end
        check("w1_latency", edges, 1);
        check("w1_diff", d1, x ^ y);
        check("w1_borrow", bo1, (x < y) ? 1 : 0);
        @(negedge clk);
        or1 = 1'b1;
        @(posedge clk);
        #1;
        or1 = 1'b0;
        check("w1_post_in_ready", rdy1, 1);
    endtask

    initial begin
        logic [7:0] plan_a [2];
        logic [7:0] plan_b [2];
        logic [8:0] res_q [$];
        int         k, got;

        #1;
        check("rst_valid", ov8, 0);
        check("rst_diff", d8, 0);
        check("rst_borrow", bo8, 0);
        check("rst_w1_valid", ov1, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release_in_ready", rdy8, 1);

        op8(8'd100, 8'd37, 0);
        op8(8'd5, 8'd9, 0);
        op8(8'hFF, 8'h01, 0);
        op8(8'h00, 8'h00, 0);
        op8(8'h80, 8'h01, 5);

        // Abort an operation after four shift cycles.
        @(negedge clk);
        a8 = 8'hC3; b8 = 8'h5A; iv8 = 1'b1;
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_valid", ov8, 0);
        check("midrst_diff", d8, 0);
        check("midrst_borrow", bo8, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_in_ready", rdy8, 1);
        op8(8'd3, 8'd3, 0);

        // in_valid held high throughout; only IDLE-cycle operands count.
        plan_a[0] = 8'd20; plan_b[0] = 8'd7;
        plan_a[1] = 8'd7;  plan_b[1] = 8'd20;
        k = 0;
        got = 0;
        or8 = 1'b1;
        for (int c = 0; c < 60 && got < 2; c++) begin
            @(negedge clk);
            if (ov8) begin
                res_q.push_back({bo8, d8});
                got++;
            end
            if (rdy8 && k < 2) begin
                a8 = plan_a[k]; b8 = plan_b[k]; iv8 = 1'b1;
                k++;
            end else begin
                a8 = 8'($urandom); b8 = 8'($urandom); iv8 = !rdy8;
            end
        end
        iv8 = 1'b0;
        @(posedge clk);
        #1;
        or8 = 1'b0;
        check("b2b_count", got, 2);
        while (res_q.size() < 2) res_q.push_back(9'h1FF);
        check("b2b_first", res_q[0], {1'b0, 8'd13});
        check("b2b_second", res_q[1], {1'b1, 8'hF3});

        for (int i = 0; i < 10; i++) begin
            op8(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
        end

        op1(1'b0, 1'b0);
        op1(1'b0, 1'b1);
        op1(1'b1, 1'b0);
        op1(1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
